// File: rtl/control_distributor_if.sv
// ============================================================================
// control_distributor_if : input-FIFO, consumer-FIFO and status bundle
// Revision 1.0
// ============================================================================
`default_nettype none

interface control_distributor_if #(
    parameter int PORTS      = 32,
    parameter int DATA_WIDTH = 32,
    parameter int IDX_WIDTH  = 5,
    parameter int CNT_WIDTH  = 16
);
    logic                              start;
    logic                              fifo_in_empty;
    logic [IDX_WIDTH+DATA_WIDTH:0]     fifo_in_data;
    logic [PORTS-1:0]                  consumer_full;
    logic                              rd_fifo_in;
    logic [PORTS-1:0]                  wr_data_en;
    logic [DATA_WIDTH-1:0]             data_out;
    logic                              drop;
    logic [CNT_WIDTH-1:0]              dispatch_count;

    modport master (
        input  start,
        input  fifo_in_empty,
        input  fifo_in_data,
        input  consumer_full,
        output rd_fifo_in,
        output wr_data_en,
        output data_out,
        output drop,
        output dispatch_count
    );

    modport slave (
        output start,
        output fifo_in_empty,
        output fifo_in_data,
        output consumer_full,
        input  rd_fifo_in,
        input  wr_data_en,
        input  data_out,
        input  drop,
        input  dispatch_count
    );
endinterface

`default_nettype wire

// File: rtl/control_distributor.sv
// ============================================================================
// control_distributor : drains the shared input FIFO into per-node FIFOs
// Revision 1.0
// ============================================================================
`default_nettype none

module control_distributor #(
    parameter int PORTS      = 32,
    parameter int DATA_WIDTH = 32,
    parameter int IDX_WIDTH  = 5,
    parameter int CNT_WIDTH  = 16
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    control_distributor_if.master     bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RD    = 2'd1;
    localparam logic [1:0] S_LATCH = 2'd2;
    localparam logic [1:0] S_CHECK = 2'd3;

    localparam logic [IDX_WIDTH:0] DEST_LIMIT = (IDX_WIDTH+1)'(PORTS);

    logic [1:0]            state_q,   state_d;
    logic                  bcast_q,   bcast_d;
    logic [IDX_WIDTH-1:0]  dest_q,    dest_d;
    logic [DATA_WIDTH-1:0] payload_q, payload_d;
    logic                  rd_q,      rd_d;
    logic [PORTS-1:0]      wr_q,      wr_d;
    logic [DATA_WIDTH-1:0] data_q,    data_d;
    logic                  drop_q,    drop_d;
    logic [CNT_WIDTH-1:0]  cnt_q,     cnt_d;

    logic [PORTS-1:0]      dest_mask;
    logic                  dest_oob;
    logic                  can_write;
    logic                  word_done;

    // An out-of-range dest shifts the mask to zero, but dest_oob is checked first.
    assign dest_mask = PORTS'(1) << dest_q;
    assign dest_oob  = ({1'b0, dest_q} >= DEST_LIMIT);
    assign can_write = bcast_q ? (bus.consumer_full == '0)
                               : (!dest_oob && ((bus.consumer_full & dest_mask) == '0));
    assign word_done = can_write || (!bcast_q && dest_oob);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            bcast_q   <= 1'b0;
            dest_q    <= '0;
            payload_q <= '0;
            rd_q      <= 1'b0;
            wr_q      <= '0;
            data_q    <= '0;
            drop_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            bcast_q   <= bcast_d;
            dest_q    <= dest_d;
            payload_q <= payload_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            data_q    <= data_d;
            drop_q    <= drop_d;
            cnt_q     <= cnt_d;
        end
    end

    // With start low everything below holds, including the latched word.
    always_comb begin
        state_d   = state_q;
        bcast_d   = bcast_q;
        dest_d    = dest_q;
        payload_d = payload_q;
        if (bus.start) begin
            case (state_q)
                S_IDLE:  if (!bus.fifo_in_empty) state_d = S_RD;
                S_RD:    state_d = S_LATCH;
                S_LATCH: begin
                    bcast_d   = bus.fifo_in_data[IDX_WIDTH+DATA_WIDTH];
                    dest_d    = bus.fifo_in_data[IDX_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
                    payload_d = bus.fifo_in_data[DATA_WIDTH-1:0];
                    state_d   = S_CHECK;
                end
                S_CHECK: if (word_done) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        rd_d   = 1'b0;
        wr_d   = '0;
        drop_d = 1'b0;
        data_d = data_q;
        cnt_d  = cnt_q;
        if (bus.start) begin
            case (state_q)
                S_IDLE:  rd_d = !bus.fifo_in_empty;
                S_CHECK: begin
                    if (can_write) begin
                        wr_d   = bcast_q ? '1 : dest_mask;
                        data_d = payload_q;
                        cnt_d  = cnt_q + CNT_WIDTH'(1);
                    end else if (!bcast_q && dest_oob) begin
                        drop_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.rd_fifo_in     = rd_q;
    assign bus.wr_data_en     = wr_q;
    assign bus.data_out       = data_q;
    assign bus.drop           = drop_q;
    assign bus.dispatch_count = cnt_q;

endmodule

`default_nettype wire
